cic_sample_buffer: RTL and testbench

CIC_SAMPLE_BUFFER -- requirements
Module: cic_sample_buffer

---
 rtl/cic_pkg.sv | 20 ++
 rtl/sample_fifo.sv | 80 ++++++++
 rtl/cic_sample_buffer.sv | 98 +++++++++
 tb/tb_cic_sample_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// ============================================================================
// cic_pkg: shared defaults for the CIC sample buffer slice.
// Rev 1.0
// ============================================================================
`default_nettype none

package cic_pkg;

  localparam int unsigned c_DATA_W_DEF   = 10;
  localparam int unsigned c_DEPTH_DEF    = 16;
  localparam int unsigned c_AVG_LOG2_DEF = 2;

  // A one-entry history still needs a one-bit pointer.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// sample_fifo: first-word-fall-through FIFO with level count and sticky drop flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module sample_fifo
  import cic_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W_DEF,
  parameter int unsigned DEPTH  = c_DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o
);

  localparam int unsigned c_AW = $clog2(DEPTH);
  localparam int unsigned c_LW = c_AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_LW-1:0]   r_level;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Fullness is judged before any same-cycle pop, so a write into a full
  // FIFO is always dropped.
  assign w_full  = (r_level == c_LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = wr_en_i & ~w_full;
  assign w_pop   = rd_en_i & ~w_empty;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase
      if (wr_en_i & w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push & ~clear_i) r_mem[r_wr_ptr] <= wr_data_i;
  end

  assign valid_o    = ~w_empty;
  assign rd_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level_o    = r_level;
  assign overflow_o = r_overflow;

endmodule

`default_nettype wire

// File: rtl/cic_sample_buffer.sv
// ============================================================================
// cic_sample_buffer: strobes CIC samples on cic_clk_i rising edges into a FWFT FIFO.
// Define CIC_SAMPLE_BUFFER_AVG_EN to write a 2^AVG_LOG2 moving average instead.  Rev 1.0
// ============================================================================
`default_nettype none

module cic_sample_buffer
  import cic_pkg::*;
#(
  parameter int unsigned DATA_W   = c_DATA_W_DEF,
  parameter int unsigned DEPTH    = c_DEPTH_DEF,
  parameter int unsigned AVG_LOG2 = c_AVG_LOG2_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   cic_clk_i,
  input  logic [DATA_W-1:0]      sample_i,
  input  logic                   clear_i,
  output logic [DATA_W-1:0]      m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
);

  logic              r_cic_clk_q;
  logic              r_wr_pend;
  logic [DATA_W-1:0] r_wr_data;
  logic              w_strobe;
  logic [DATA_W-1:0] w_proc;

  assign w_strobe = cic_clk_i & ~r_cic_clk_q;

`ifdef CIC_SAMPLE_BUFFER_AVG_EN
  localparam int unsigned c_HLEN  = 1 << AVG_LOG2;
  localparam int unsigned c_HPW   = ptr_w(c_HLEN);
  localparam int unsigned c_SUM_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0]  r_hist [c_HLEN];
  logic [c_HPW-1:0]   r_hptr;
  logic [c_SUM_W-1:0] r_sum;
  logic [c_SUM_W-1:0] w_sum_next;

  // Running sum never underflows: the entry being retired is part of it.
  assign w_sum_next = r_sum + c_SUM_W'(sample_i) - c_SUM_W'(r_hist[r_hptr]);
  assign w_proc     = DATA_W'(w_sum_next >> AVG_LOG2);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(c_HLEN); i++) r_hist[i] <= '0;
      r_hptr <= '0;
      r_sum  <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < int'(c_HLEN); i++) r_hist[i] <= '0;
      r_hptr <= '0;
      r_sum  <= '0;
    end else if (w_strobe) begin
      r_hist[r_hptr] <= sample_i;
      r_hptr         <= (r_hptr == c_HPW'(c_HLEN - 1)) ? '0 : r_hptr + c_HPW'(1);
      r_sum          <= w_sum_next;
    end
  end
`else
  assign w_proc = sample_i;
`endif

  // One capture stage keeps write latency identical with or without averaging.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cic_clk_q <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_data   <= '0;
    end else begin
      r_cic_clk_q <= cic_clk_i;
      r_wr_pend   <= w_strobe & ~clear_i;
      if (w_strobe) r_wr_data <= w_proc;
    end
  end

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clear_i    (clear_i),
    .wr_en_i    (r_wr_pend),
    .wr_data_i  (r_wr_data),
    .rd_en_i    (m_ready_i),
    .rd_data_o  (m_data_o),
    .valid_o    (m_valid_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_cic_sample_buffer.sv
// ============================================================================
// tb_cic_sample_buffer: directed bench with a queue-based reference model for two depths.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cic_sample_buffer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cic_clk = 1'b0;
  logic [9:0] sample = '0;
  logic       clear = 1'b0;
  logic       ready16 = 1'b0;
  logic       ready4 = 1'b0;

  logic [9:0] data16, data4;
  logic       valid16, valid4;
  logic [4:0] level16;
  logic [2:0] level4;
  logic       ovf16, ovf4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cic_sample_buffer #(.DATA_W(10), .DEPTH(16), .AVG_LOG2(2)) dut16 (
    .clk_i(clk), .rstn_i(rstn), .cic_clk_i(cic_clk), .sample_i(sample), .clear_i(clear),
    .m_data_o(data16), .m_valid_o(valid16), .m_ready_i(ready16),
    .level_o(level16), .overflow_o(ovf16)
  );

  cic_sample_buffer #(.DATA_W(10), .DEPTH(4), .AVG_LOG2(2)) dut4 (
    .clk_i(clk), .rstn_i(rstn), .cic_clk_i(cic_clk), .sample_i(sample), .clear_i(clear),
    .m_data_o(data4), .m_valid_o(valid4), .m_ready_i(ready4),
    .level_o(level4), .overflow_o(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as queues, average over the most recent samples.
  logic [9:0] q16[$];
  logic [9:0] q4[$];
  int         hist[$];
  bit         m_ovf16, m_ovf4, m_prev, m_pend, m_stb, m_full16, m_full4;
  logic [9:0] m_pend_val;

  function automatic logic [9:0] process(input logic [9:0] s);
`ifdef CIC_SAMPLE_BUFFER_AVG_EN
    int sum = 0;
    hist.push_back(int'(s));
    if (hist.size() > 4) void'(hist.pop_front());
    foreach (hist[i]) sum += hist[i];
    return 10'(sum / 4);
`else
    return s;
`endif
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q16.delete(); q4.delete(); hist.delete();
      m_ovf16 = 0; m_ovf4 = 0; m_prev = 0; m_pend = 0;
    end else begin
      m_stb  = cic_clk && !m_prev;
      m_prev = cic_clk;
      if (clear) begin
        q16.delete(); q4.delete(); hist.delete();
        m_ovf16 = 0; m_ovf4 = 0; m_pend = 0;
      end else begin
        m_full16 = q16.size() >= 16;
        m_full4  = q4.size() >= 4;
        if (ready16 && q16.size() > 0) void'(q16.pop_front());
        if (ready4 && q4.size() > 0) void'(q4.pop_front());
        if (m_pend) begin
          if (m_full16) m_ovf16 = 1; else q16.push_back(m_pend_val);
          if (m_full4)  m_ovf4 = 1;  else q4.push_back(m_pend_val);
        end
        m_pend = m_stb;
        if (m_stb) m_pend_val = process(sample);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("model_level16", 32'(level16), 32'(q16.size()));
      check("model_valid16", 32'(valid16), 32'(q16.size() != 0));
      if (q16.size() != 0) check("model_data16", 32'(data16), 32'(q16[0]));
      check("model_ovf16", 32'(ovf16), 32'(m_ovf16));
      check("model_level4", 32'(level4), 32'(q4.size()));
      check("model_valid4", 32'(valid4), 32'(q4.size() != 0));
      if (q4.size() != 0) check("model_data4", 32'(data4), 32'(q4[0]));
      check("model_ovf4", 32'(ovf4), 32'(m_ovf4));
    end
  end

  task automatic strobe(input logic [9:0] v);
    @(posedge clk); #1;
    cic_clk = 1'b1; sample = v;
    @(posedge clk); #1;
    cic_clk = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic pop16(input string name, input logic [9:0] exp);
    check(name, 32'(data16), 32'(exp));
    ready16 = 1'b1;
    @(posedge clk); #1; ready16 = 1'b0;
  endtask

  task automatic pop4(input string name, input logic [9:0] exp);
    check(name, 32'(data4), 32'(exp));
    ready4 = 1'b1;
    @(posedge clk); #1; ready4 = 1'b0;
  endtask

  logic [9:0] e_first, e_mid, e_drop2;
  logic [9:0] e32 [4];
  logic [9:0] e33 [5];

  initial begin
`ifdef CIC_SAMPLE_BUFFER_AVG_EN
    e_first = 10'h055; e_mid = 10'd2; e_drop2 = 10'd7;
    e32[0] = 10'd0; e32[1] = 10'd0; e32[2] = 10'd1; e32[3] = 10'd2;
    e33[0] = 10'd2; e33[1] = 10'd4; e33[2] = 10'd6; e33[3] = 10'd8; e33[4] = 10'd6;
`else
    e_first = 10'h155; e_mid = 10'd9; e_drop2 = 10'd20;
    e32[0] = 10'd1; e32[1] = 10'd2; e32[2] = 10'd3; e32[3] = 10'd4;
    e33[0] = 10'd8; e33[1] = 10'd8; e33[2] = 10'd8; e33[3] = 10'd8; e33[4] = 10'd0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid16), 0);
    check("rst_data", 32'(data16), 0);
    check("rst_level", 32'(level16), 0);
    check("rst_ovf", 32'(ovf16), 0);
    @(negedge clk); rstn = 1'b1;

    // First sample latency
    strobe(10'h155);
    check("lat_valid_early", 32'(valid16), 0);
    @(posedge clk); #1;
    check("lat_valid", 32'(valid16), 1);
    check("lat_data", 32'(data16), 32'(e_first));
    check("lat_level", 32'(level16), 1);
    do_clear();
    check("clr_level", 32'(level16), 0);

    // Overflow on the shallow FIFO
    for (int i = 1; i <= 6; i++) strobe(10'(i));
    repeat (2) @(posedge clk); #1;
    check("ovf_level4", 32'(level4), 4);
    check("ovf_flag4", 32'(ovf4), 1);
    check("ovf_level16", 32'(level16), 6);
    for (int i = 0; i < 4; i++) pop4("ovf_pop4", e32[i]);
    check("ovf_empty4", 32'(level4), 0);
    check("ovf_sticky4", 32'(ovf4), 1);

    // Averaging pattern
    do_clear();
    strobe(10'd8); strobe(10'd8); strobe(10'd8); strobe(10'd8); strobe(10'd0);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) pop16("avg_pop16", e33[i]);

    // Write into full FIFO while popping
    do_clear();
    strobe(10'd10); strobe(10'd20); strobe(10'd30); strobe(10'd40);
    repeat (2) @(posedge clk); #1;
    check("full_level4", 32'(level4), 4);
    check("full_noovf4", 32'(ovf4), 0);
    strobe(10'd50);
    ready4 = 1'b1;
    @(posedge clk); #1; ready4 = 1'b0;
    check("fullpop_level4", 32'(level4), 3);
    check("fullpop_ovf4", 32'(ovf4), 1);
    check("fullpop_data4", 32'(data4), 32'(e_drop2));

    // Clear coincident with a strobe
    do_clear();
    for (int i = 1; i <= 5; i++) strobe(10'(i));
    repeat (2) @(posedge clk); #1;
    check("pre_clr_ovf4", 32'(ovf4), 1);
    cic_clk = 1'b1; sample = 10'h3FF; clear = 1'b1;
    @(posedge clk); #1; cic_clk = 1'b0; clear = 1'b0;
    check("clr_level16", 32'(level16), 0);
    check("clr_valid16", 32'(valid16), 0);
    check("clr_ovf4", 32'(ovf4), 0);
    repeat (3) @(posedge clk); #1;
    check("clr_nostore16", 32'(level16), 0);

    // Reset mid-stream with cic_clk held high
    strobe(10'd7);
    @(posedge clk); #1;
    cic_clk = 1'b1; sample = 10'd9;
    #2 rstn = 1'b0;
    #1;
    check("arst_level16", 32'(level16), 0);
    check("arst_valid16", 32'(valid16), 0);
    check("arst_data16", 32'(data16), 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("arst_restrobe_level", 32'(level16), 1);
    check("arst_restrobe_data", 32'(data16), 32'(e_mid));
    cic_clk = 1'b0;

    // Random backpressure over many strobes, pointers wrap
    do_clear();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cic_clk = 1'b1; sample = 10'($urandom_range(0, 1023));
      ready16 = ($urandom_range(0, 3) != 0); ready4 = $urandom_range(0, 1) != 0;
      @(posedge clk); #1;
      cic_clk = 1'b0;
      ready16 = ($urandom_range(0, 3) != 0); ready4 = $urandom_range(0, 1) != 0;
    end
    ready16 = 1'b1; ready4 = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("rand_drained16", 32'(level16), 0);
    check("rand_noovf16", 32'(ovf16), 0);
    ready16 = 1'b0; ready4 = 1'b0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
